// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions for the hazard scoreboard: tracker entry type,
// pipeline stage indices, ready-stage codes and hazard priority cases.
package cpu_defs;

  localparam int CPU_REG_AW = 5;
  localparam int CPU_RDY_W  = 2;

  localparam int STG_F   = 0;
  localparam int STG_D   = 1;
  localparam int STG_E   = 2;
  localparam int STG_M   = 3;
  localparam int STG_W   = 4;
  localparam int NUM_STG = 5;

  localparam logic [CPU_RDY_W-1:0] RDY_ALU = 2'd1;
  localparam logic [CPU_RDY_W-1:0] RDY_MEM = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [CPU_REG_AW-1:0] waddr;
    logic [CPU_RDY_W-1:0]  rdy;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Listed in decreasing priority; PRI_NONE means no hazard action this cycle.
  typedef enum logic [3:0] {
    PRI_NONE,
    PRI_DMEM,
    PRI_EXC_IMEM,
    PRI_EXC,
    PRI_MDU,
    PRI_IMEM_BR,
    PRI_IMEM,
    PRI_BR,
    PRI_DH
  } pri_case_t;

endpackage

// File: rtl/hazard_scoreboard_tracker.sv
// sb_tracker: shift tracker of in-flight register producers (entry 0=E, 1=M, 2=W)
// plus youngest-match search, data-hazard detection and forward selects.
module sb_tracker
  import cpu_defs::*;
#(
  parameter int REG_AW      = CPU_REG_AW,
  parameter int TRACK_DEPTH = 3,
  parameter int RDY_W       = CPU_RDY_W,
  parameter int FWD_W       = $clog2(TRACK_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STG_W:STG_D]     i_stall,
  input  logic [STG_W:STG_E]     i_flush,
  input  logic                   i_killM,
  input  logic                   i_dWen,
  input  logic [REG_AW-1:0]      i_dWaddr,
  input  logic [RDY_W-1:0]       i_dRdy,
  input  logic [REG_AW-1:0]      i_dRs,
  input  logic [REG_AW-1:0]      i_dRt,
  input  logic                   i_dUseRs,
  input  logic                   i_dUseRt,
  input  logic                   i_dEarly,
  input  logic [REG_AW-1:0]      i_eRs,
  input  logic [REG_AW-1:0]      i_eRt,
  output logic                   o_dh,
  output logic [FWD_W-1:0]       o_fwdDA,
  output logic [FWD_W-1:0]       o_fwdDB,
  output logic [FWD_W-1:0]       o_fwdEA,
  output logic [FWD_W-1:0]       o_fwdEB
);

  sb_entry_t r_entry [TRACK_DEPTH];
  sb_entry_t w_src   [TRACK_DEPTH];
  sb_entry_t w_next  [TRACK_DEPTH];

  logic [FWD_W:0] w_hitDA, w_hitDB, w_hitEA, w_hitEB;
  logic           w_useDA, w_useDB, w_useEA, w_useEB;

  always_comb begin
    w_src[0] = '{valid: i_dWen && (i_dWaddr != '0),
                 waddr: CPU_REG_AW'(i_dWaddr),
                 rdy:   CPU_RDY_W'(i_dRdy)};
    for (int k = 1; k < TRACK_DEPTH; k++) w_src[k] = r_entry[k-1];
  end

  // An exception in M kills the instruction that would otherwise move into W.
  always_comb begin
    for (int k = 0; k < TRACK_DEPTH; k++) begin
      if (i_flush[STG_E+k])
        w_next[k] = SB_BUBBLE;
      else if (i_stall[STG_E+k])
        w_next[k] = r_entry[k];
      else if (i_stall[STG_D+k] || (i_killM && (k == STG_W - STG_E)))
        w_next[k] = SB_BUBBLE;
      else
        w_next[k] = w_src[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TRACK_DEPTH; k++) r_entry[k] <= SB_BUBBLE;
    end else begin
      for (int k = 0; k < TRACK_DEPTH; k++) r_entry[k] <= w_next[k];
    end
  end

  function automatic logic [FWD_W:0] youngest(input logic [REG_AW-1:0] src, input int lo);
    logic [FWD_W:0] res;
    res = '0;
    for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
      if ((k >= lo) && r_entry[k].valid && (r_entry[k].waddr == CPU_REG_AW'(src)))
        res = {1'b1, FWD_W'(k)};
    end
    return res;
  endfunction

  function automatic logic mustStall(input logic [FWD_W:0] hit, input logic early);
    int k;
    int r;
    k = int'(hit[FWD_W-1:0]);
    if (!hit[FWD_W]) return 1'b0;
    r = int'(r_entry[k].rdy);
    if (early) return (k == 0) || (r > k);
    return r > k + 1;
  endfunction

  always_comb begin
    w_useDA = i_dUseRs && (i_dRs != '0);
    w_useDB = i_dUseRt && (i_dRt != '0);
    w_useEA = (i_eRs != '0);
    w_useEB = (i_eRt != '0);
    w_hitDA = youngest(i_dRs, 0);
    w_hitDB = youngest(i_dRt, 0);
    w_hitEA = youngest(i_eRs, 1);
    w_hitEB = youngest(i_eRt, 1);
  end

  // Entry 0 never forwards, so a youngest hit at k=0 yields select 0 naturally.
  always_comb begin
    o_dh    = (w_useDA && mustStall(w_hitDA, i_dEarly)) ||
              (w_useDB && mustStall(w_hitDB, i_dEarly));
    o_fwdDA = (w_useDA && w_hitDA[FWD_W]) ? w_hitDA[FWD_W-1:0] : '0;
    o_fwdDB = (w_useDB && w_hitDB[FWD_W]) ? w_hitDB[FWD_W-1:0] : '0;
    o_fwdEA = (w_useEA && w_hitEA[FWD_W]) ? w_hitEA[FWD_W-1:0] : '0;
    o_fwdEB = (w_useEB && w_hitEB[FWD_W]) ? w_hitEB[FWD_W-1:0] : '0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: prioritised stall/flush generation over the sb_tracker.
// Define HAZARD_PERF_CNT_EN to build the four saturating stall-cause counters.
module hazard_scoreboard
  import cpu_defs::*;
#(
  parameter int REG_AW      = CPU_REG_AW,
  parameter int TRACK_DEPTH = 3,
  parameter int RDY_W       = CPU_RDY_W,
  parameter int FWD_W       = $clog2(TRACK_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_AW-1:0]  d_rs,
  input  logic [REG_AW-1:0]  d_rt,
  input  logic               d_use_rs,
  input  logic               d_use_rt,
  input  logic               d_early,
  input  logic               d_wen,
  input  logic [REG_AW-1:0]  d_waddr,
  input  logic [RDY_W-1:0]   d_rdy,
  input  logic [REG_AW-1:0]  e_rs,
  input  logic [REG_AW-1:0]  e_rt,
  input  logic               mdu_busy,
  input  logic               imem_busy,
  input  logic               dmem_busy,
  input  logic               exc_flush,
  input  logic               bfrome,
  output logic [NUM_STG-1:0] stall,
  output logic [NUM_STG-1:0] flush,
  output logic [FWD_W-1:0]   fwd_d_a,
  output logic [FWD_W-1:0]   fwd_d_b,
  output logic [FWD_W-1:0]   fwd_e_a,
  output logic [FWD_W-1:0]   fwd_e_b,
  input  logic [1:0]         perf_sel,
  output logic [31:0]        perf_cnt
);

  logic      w_dh;
  pri_case_t w_case;

  sb_tracker #(
    .REG_AW      (REG_AW),
    .TRACK_DEPTH (TRACK_DEPTH),
    .RDY_W       (RDY_W),
    .FWD_W       (FWD_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_stall  (stall[STG_W:STG_D]),
    .i_flush  (flush[STG_W:STG_E]),
    .i_killM  (w_case == PRI_EXC),
    .i_dWen   (d_wen),
    .i_dWaddr (d_waddr),
    .i_dRdy   (d_rdy),
    .i_dRs    (d_rs),
    .i_dRt    (d_rt),
    .i_dUseRs (d_use_rs),
    .i_dUseRt (d_use_rt),
    .i_dEarly (d_early),
    .i_eRs    (e_rs),
    .i_eRt    (e_rt),
    .o_dh     (w_dh),
    .o_fwdDA  (fwd_d_a),
    .o_fwdDB  (fwd_d_b),
    .o_fwdEA  (fwd_e_a),
    .o_fwdEB  (fwd_e_b)
  );

  // An exception waits for an outstanding fetch so the redirect is not lost.
  always_comb begin
    w_case = PRI_NONE;
    if (dmem_busy)                   w_case = PRI_DMEM;
    else if (exc_flush && imem_busy) w_case = PRI_EXC_IMEM;
    else if (exc_flush)              w_case = PRI_EXC;
    else if (mdu_busy)               w_case = PRI_MDU;
    else if (imem_busy && bfrome)    w_case = PRI_IMEM_BR;
    else if (imem_busy)              w_case = PRI_IMEM;
    else if (bfrome)                 w_case = PRI_BR;
    else if (w_dh)                   w_case = PRI_DH;
  end

  always_comb begin
    stall = '0;
    flush = '0;
    case (w_case)
      PRI_DMEM, PRI_EXC_IMEM, PRI_MDU, PRI_IMEM_BR: stall = '1;
      PRI_EXC: flush[STG_M:STG_F] = '1;
      PRI_IMEM, PRI_DH: begin
        stall[STG_F] = 1'b1;
        stall[STG_D] = 1'b1;
        flush[STG_E] = 1'b1;
      end
      PRI_BR: flush[STG_D] = 1'b1;
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perfCnt [4];
  logic [3:0]  w_perfHit;

  always_comb begin
    w_perfHit    = '0;
    w_perfHit[0] = (w_case == PRI_DH);
    w_perfHit[1] = (w_case == PRI_DMEM) || (w_case == PRI_EXC_IMEM) ||
                   (w_case == PRI_IMEM_BR) || (w_case == PRI_IMEM);
    w_perfHit[2] = (w_case == PRI_MDU);
    w_perfHit[3] = (w_case == PRI_EXC) || (w_case == PRI_BR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_perfCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_perfHit[i] && (r_perfCnt[i] != '1)) r_perfCnt[i] <= r_perfCnt[i] + 32'd1;
    end
  end

  assign perf_cnt = r_perfCnt[perf_sel];
`else
  logic w_unusedPerfSel;
  assign w_unusedPerfSel = ^perf_sel;
  assign perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
// Counter checks run only when HAZARD_PERF_CNT_EN is defined for the build.
module tb_hazard_scoreboard;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  d_rs, d_rt, d_waddr, e_rs, e_rt;
  logic        d_use_rs, d_use_rt, d_early, d_wen;
  logic [1:0]  d_rdy;
  logic        mdu_busy, imem_busy, dmem_busy, exc_flush, bfrome;
  logic [4:0]  stall, flush;
  logic [1:0]  fwd_d_a, fwd_d_b, fwd_e_a, fwd_e_b;
  logic [1:0]  perf_sel;
  logic [31:0] perf_cnt;

  int compared   = 0;
  int mismatched = 0;

  hazard_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_use_rs  (d_use_rs),
    .d_use_rt  (d_use_rt),
    .d_early   (d_early),
    .d_wen     (d_wen),
    .d_waddr   (d_waddr),
    .d_rdy     (d_rdy),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .mdu_busy  (mdu_busy),
    .imem_busy (imem_busy),
    .dmem_busy (dmem_busy),
    .exc_flush (exc_flush),
    .bfrome    (bfrome),
    .stall     (stall),
    .flush     (flush),
    .fwd_d_a   (fwd_d_a),
    .fwd_d_b   (fwd_d_b),
    .fwd_e_a   (fwd_e_a),
    .fwd_e_b   (fwd_e_b),
    .perf_sel  (perf_sel),
    .perf_cnt  (perf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    d_rs = '0; d_rt = '0; d_waddr = '0; e_rs = '0; e_rt = '0;
    d_use_rs = 0; d_use_rt = 0; d_early = 0; d_wen = 0; d_rdy = '0;
    mdu_busy = 0; imem_busy = 0; dmem_busy = 0; exc_flush = 0; bfrome = 0;
    perf_sel = '0;
  endtask

  task automatic drain();
    idleInputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    d_rs = 5'd5; d_use_rs = 1; e_rs = 5'd5;
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 5'b00000) begin mismatched++; $display("[TB] FAIL reset_stall: got %b want 00000", stall); end
    compared++;
    if (flush !== 5'b00000) begin mismatched++; $display("[TB] FAIL reset_flush: got %b want 00000", flush); end
    compared++;
    if (fwd_d_a !== 2'd0 || fwd_e_a !== 2'd0) begin
      mismatched++; $display("[TB] FAIL reset_fwd: got d=%0d e=%0d want 0 0", fwd_d_a, fwd_e_a);
    end
    @(negedge clk);
    rst = 1'b0;
    drain();
  endtask

  task automatic test_alu_forward();
    d_wen = 1; d_waddr = 5'd5; d_rdy = RDY_ALU;
    @(negedge clk);
    idleInputs(); d_rs = 5'd5; d_use_rs = 1;
    #1;
    compared++;
    if (stall !== 5'b00000 || flush !== 5'b00000) begin
      mismatched++; $display("[TB] FAIL alu_no_stall: got stall=%b flush=%b want 00000 00000", stall, flush);
    end
    @(negedge clk);
    idleInputs(); e_rs = 5'd5;
    #1;
    compared++;
    if (fwd_e_a !== 2'd1) begin mismatched++; $display("[TB] FAIL alu_fwd_e_m: got %0d want 1", fwd_e_a); end
    @(negedge clk);
    #1;
    compared++;
    if (fwd_e_a !== 2'd2) begin mismatched++; $display("[TB] FAIL alu_fwd_e_w: got %0d want 2", fwd_e_a); end
    @(negedge clk);
    #1;
    compared++;
    if (fwd_e_a !== 2'd0) begin mismatched++; $display("[TB] FAIL alu_retired: got %0d want 0", fwd_e_a); end
    drain();
  endtask

  task automatic test_load_use();
    d_wen = 1; d_waddr = 5'd7; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd7; d_use_rs = 1;
    #1;
    compared++;
    if (stall !== 5'b00011 || flush !== 5'b00100) begin
      mismatched++; $display("[TB] FAIL load_use_stall: got stall=%b flush=%b want 00011 00100", stall, flush);
    end
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 5'b00000 || flush !== 5'b00000) begin
      mismatched++; $display("[TB] FAIL load_use_release: got stall=%b flush=%b want 00000 00000", stall, flush);
    end
    compared++;
    if (fwd_d_a !== 2'd1) begin mismatched++; $display("[TB] FAIL load_fwd_d: got %0d want 1", fwd_d_a); end
    @(negedge clk);
    idleInputs(); e_rs = 5'd7; e_rt = 5'd7;
    #1;
    compared++;
    if (fwd_e_a !== 2'd2 || fwd_e_b !== 2'd2) begin
      mismatched++; $display("[TB] FAIL load_fwd_e: got a=%0d b=%0d want 2 2", fwd_e_a, fwd_e_b);
    end
    drain();
  endtask

  task automatic test_early_branch();
    d_wen = 1; d_waddr = 5'd3; d_rdy = RDY_ALU;
    @(negedge clk);
    idleInputs(); d_rs = 5'd3; d_rt = 5'd3; d_use_rs = 1; d_use_rt = 1; d_early = 1;
    #1;
    compared++;
    if (stall !== 5'b00011 || flush !== 5'b00100) begin
      mismatched++; $display("[TB] FAIL early_stall: got stall=%b flush=%b want 00011 00100", stall, flush);
    end
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 5'b00000) begin mismatched++; $display("[TB] FAIL early_release: got %b want 00000", stall); end
    compared++;
    if (fwd_d_a !== 2'd1 || fwd_d_b !== 2'd1) begin
      mismatched++; $display("[TB] FAIL early_fwd_d: got a=%0d b=%0d want 1 1", fwd_d_a, fwd_d_b);
    end
    drain();
  endtask

  task automatic test_zero_and_use();
    d_wen = 1; d_waddr = 5'd0; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd0; d_use_rs = 1; d_early = 1;
    #1;
    compared++;
    if (stall !== 5'b00000) begin mismatched++; $display("[TB] FAIL r0_untracked: got %b want 00000", stall); end
    drain();
    d_wen = 1; d_waddr = 5'd9; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd9; d_rt = 5'd9; d_early = 1;
    #1;
    compared++;
    if (stall !== 5'b00000) begin mismatched++; $display("[TB] FAIL use_bits_clear: got %b want 00000", stall); end
    d_use_rt = 1;
    #1;
    compared++;
    if (stall !== 5'b00011) begin mismatched++; $display("[TB] FAIL use_rt_stall: got %b want 00011", stall); end
    drain();
  endtask

  task automatic test_exc_flush();
    for (int i = 0; i < 3; i++) begin
      d_wen = 1; d_waddr = 5'(10 + i); d_rdy = RDY_ALU;
      @(negedge clk);
    end
    idleInputs(); exc_flush = 1; e_rs = 5'd11;
    #1;
    compared++;
    if (stall !== 5'b00000 || flush !== 5'b01111) begin
      mismatched++; $display("[TB] FAIL exc_flush_vec: got stall=%b flush=%b want 00000 01111", stall, flush);
    end
    compared++;
    if (fwd_e_a !== 2'd1) begin mismatched++; $display("[TB] FAIL exc_pre_fwd: got %0d want 1", fwd_e_a); end
    @(negedge clk);
    idleInputs(); e_rs = 5'd11; e_rt = 5'd10; d_rs = 5'd12; d_use_rs = 1; d_early = 1;
    #1;
    compared++;
    if (stall !== 5'b00000) begin mismatched++; $display("[TB] FAIL exc_tracker_e: got %b want 00000", stall); end
    compared++;
    if (fwd_e_a !== 2'd0 || fwd_e_b !== 2'd0 || fwd_d_a !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL exc_tracker_empty: got e_a=%0d e_b=%0d d_a=%0d want 0 0 0", fwd_e_a, fwd_e_b, fwd_d_a);
    end
    drain();
  endtask

  task automatic test_stall_all();
    d_wen = 1; d_waddr = 5'd7; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd7; d_use_rs = 1; dmem_busy = 1; bfrome = 1;
    #1;
    compared++;
    if (stall !== 5'b11111 || flush !== 5'b00000) begin
      mismatched++; $display("[TB] FAIL stall_all: got stall=%b flush=%b want 11111 00000", stall, flush);
    end
    @(negedge clk);
    dmem_busy = 0; bfrome = 0;
    #1;
    compared++;
    if (stall !== 5'b00011 || flush !== 5'b00100) begin
      mismatched++; $display("[TB] FAIL stall_all_hold: got stall=%b flush=%b want 00011 00100", stall, flush);
    end
    drain();
  endtask

  typedef struct {
    logic [4:0] ctl;
    logic [4:0] expStall;
    logic [4:0] expFlush;
  } prio_vec_t;

  task automatic test_priority();
    // ctl = {exc_flush, imem_busy, mdu_busy, bfrome, dmem_busy}
    prio_vec_t vecs [7];
    vecs[0] = '{5'b11000, 5'b11111, 5'b00000};
    vecs[1] = '{5'b10000, 5'b00000, 5'b01111};
    vecs[2] = '{5'b00100, 5'b11111, 5'b00000};
    vecs[3] = '{5'b01010, 5'b11111, 5'b00000};
    vecs[4] = '{5'b01000, 5'b00011, 5'b00100};
    vecs[5] = '{5'b00010, 5'b00000, 5'b00010};
    vecs[6] = '{5'b10100, 5'b00000, 5'b01111};
    for (int i = 0; i < 7; i++) begin
      idleInputs();
      {exc_flush, imem_busy, mdu_busy, bfrome, dmem_busy} = vecs[i].ctl;
      #1;
      compared++;
      if (stall !== vecs[i].expStall || flush !== vecs[i].expFlush) begin
        mismatched++;
        $display("[TB] FAIL priority_%0d: got stall=%b flush=%b want %b %b",
                 i, stall, flush, vecs[i].expStall, vecs[i].expFlush);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    d_wen = 1; d_waddr = 5'd7; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd7; d_use_rs = 1;
    rst = 1'b1;
    #1;
    compared++;
    if (stall !== 5'b00000 || flush !== 5'b00000) begin
      mismatched++; $display("[TB] FAIL reset_mid: got stall=%b flush=%b want 00000 00000", stall, flush);
    end
    @(negedge clk);
    rst = 1'b0;
    drain();
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    d_wen = 1; d_waddr = 5'd7; d_rdy = RDY_MEM;
    @(negedge clk);
    idleInputs(); d_rs = 5'd7; d_use_rs = 1; d_early = 1;
    @(negedge clk);
    @(negedge clk);
    idleInputs(); d_wen = 1; d_waddr = 5'd4; d_rdy = RDY_ALU;
    @(negedge clk);
    idleInputs(); d_rs = 5'd4; d_use_rs = 1; d_early = 1;
    @(negedge clk);
    idleInputs(); perf_sel = 2'd0;
    #1;
    compared++;
    if (perf_cnt !== 32'd3) begin mismatched++; $display("[TB] FAIL perf_dh: got %0d want 3", perf_cnt); end
    perf_sel = 2'd2;
    #1;
    compared++;
    if (perf_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL perf_mdu: got %0d want 0", perf_cnt); end
    bfrome = 1;
    @(negedge clk);
    bfrome = 0; perf_sel = 2'd3;
    #1;
    compared++;
    if (perf_cnt !== 32'd1) begin mismatched++; $display("[TB] FAIL perf_flush: got %0d want 1", perf_cnt); end
    rst = 1'b1; perf_sel = 2'd0;
    #1;
    compared++;
    if (perf_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL perf_reset: got %0d want 0", perf_cnt); end
    @(negedge clk);
    rst = 1'b0;
`else
    idleInputs(); perf_sel = 2'd3; bfrome = 1;
    @(negedge clk);
    #1;
    compared++;
    if (perf_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL perf_disabled: got %0d want 0", perf_cnt); end
`endif
    drain();
  endtask

  initial begin
    $display("[TB] hazard_scoreboard directed test start");
    test_reset();
    test_alu_forward();
    test_load_use();
    test_early_branch();
    test_zero_and_use();
    test_exc_flush();
    test_stall_all();
    test_priority();
    test_reset_mid();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
